// File: rtl/dino_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dino_motion_ctrl
// Description : Per-frame player sprite motion and animation controller.
//               Drives sprite origin and ROM select code for color_mapper.
// Revision    : 1.0 - initial release
// ============================================================================
module dino_motion_ctrl #(
    parameter logic        [9:0] GROUND_Y    = 10'd300,
    parameter logic        [9:0] DINO_X      = 10'd50,
    parameter logic signed [7:0] JUMP_V0     = 8'sd20,
    parameter logic signed [7:0] GRAVITY     = 8'sd1,
    parameter int                ANIM_FRAMES = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       jump_key,
    input  logic       duck_key,
    input  logic       collide,
    output logic [9:0] DinoX,
    output logic [9:0] DinoY,
    output logic [2:0] sprite_sel,
    output logic       game_active
);

    localparam int                 C_CNT_W     = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [C_CNT_W-1:0] C_ANIM_LAST = C_CNT_W'(ANIM_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_AIR  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    state_t              r_state;
    logic signed [7:0]   r_vel;
    logic [C_CNT_W-1:0]  r_anim_cnt;
    logic                r_leg;
    logic                r_jump_req;
    logic                r_jump_key_d;
    logic [9:0]          r_dino_y;
    logic [2:0]          r_sprite_sel;
    logic                r_game_active;

    state_t              w_state_nx;
    logic signed [7:0]   w_vel_nx;
    logic [C_CNT_W-1:0]  w_cnt_nx;
    logic                w_leg_nx;
    logic [9:0]          w_y_nx;
    logic signed [10:0]  w_ny;
    logic                w_rise;
    logic                w_req_nx;
    logic [2:0]          w_sel_nx;

    assign w_rise = jump_key & ~r_jump_key_d;
    // Every frame tick consumes the request; an edge in the same cycle survives it.
    assign w_req_nx = frame_tick ? w_rise : (r_jump_req | w_rise);
    assign w_ny     = $signed({1'b0, r_dino_y}) - $signed({{3{r_vel[7]}}, r_vel});

    always_comb begin
        w_state_nx = r_state;
        w_vel_nx   = r_vel;
        w_cnt_nx   = r_anim_cnt;
        w_leg_nx   = r_leg;
        w_y_nx     = r_dino_y;
        case (r_state)
            ST_IDLE: begin
                if (frame_tick && r_jump_req) begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (collide) begin
                    w_state_nx = ST_DEAD;
                end else if (frame_tick && r_jump_req) begin
                    w_state_nx = ST_AIR;
                    w_vel_nx   = JUMP_V0;
                end else if (frame_tick) begin
                    if (r_anim_cnt == C_ANIM_LAST) begin
                        w_cnt_nx = '0;
                        w_leg_nx = ~r_leg;
                    end else begin
                        w_cnt_nx = r_anim_cnt + C_CNT_W'(1);
                    end
                end
            end
            ST_AIR: begin
                if (collide) begin
                    w_state_nx = ST_DEAD;
                end else if (frame_tick) begin
                    w_vel_nx = r_vel - GRAVITY;
                    if (w_ny >= $signed({1'b0, GROUND_Y})) begin
                        w_y_nx     = GROUND_Y;
                        w_vel_nx   = '0;
                        w_state_nx = ST_RUN;
                    end else if (w_ny[10]) begin
                        w_y_nx = '0;
                    end else begin
                        w_y_nx = w_ny[9:0];
                    end
                end
            end
            default: begin
                if (frame_tick && r_jump_req) begin
                    w_state_nx = ST_RUN;
                    w_y_nx     = GROUND_Y;
                    w_vel_nx   = '0;
                    w_cnt_nx   = '0;
                    w_leg_nx   = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        w_sel_nx = 3'd0;
        case (w_state_nx)
            ST_IDLE: w_sel_nx = 3'd0;
            ST_RUN:  w_sel_nx = duck_key ? (3'd3 + {2'b00, w_leg_nx}) : (3'd1 + {2'b00, w_leg_nx});
            ST_AIR:  w_sel_nx = 3'd5;
            default: w_sel_nx = 3'd6;
        endcase
    end

    // Key history follows the pin even in reset so a held key is not seen as a fresh press.
    always_ff @(posedge Clk) begin
        r_jump_key_d <= jump_key;
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_dino_y      <= GROUND_Y;
            r_vel         <= '0;
            r_anim_cnt    <= '0;
            r_leg         <= 1'b0;
            r_jump_req    <= 1'b0;
            r_sprite_sel  <= 3'd0;
            r_game_active <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_dino_y      <= w_y_nx;
            r_vel         <= w_vel_nx;
            r_anim_cnt    <= w_cnt_nx;
            r_leg         <= w_leg_nx;
            r_jump_req    <= w_req_nx;
            r_sprite_sel  <= w_sel_nx;
            r_game_active <= (w_state_nx == ST_RUN) || (w_state_nx == ST_AIR);
        end
    end

    assign DinoX       = DINO_X;
    assign DinoY       = r_dino_y;
    assign sprite_sel  = r_sprite_sel;
    assign game_active = r_game_active;

endmodule
`default_nettype wire

// File: tb/tb_dino_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dino_motion_ctrl
// Description : Directed bench for dino_motion_ctrl with a per-cycle scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dino_motion_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       jump_key = 1'b0;
    logic       duck_key = 1'b0;
    logic       collide = 1'b0;
    logic [9:0] DinoX;
    logic [9:0] DinoY;
    logic [2:0] sprite_sel;
    logic       game_active;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string tag;
        int    y;
        int    sel;
        int    act;
    } exp_t;

    exp_t sb[$];

    // Reference model: 0 IDLE, 1 RUN, 2 AIR, 3 DEAD
    int m_state = 0;
    int m_y     = 300;
    int m_vel   = 0;
    int m_cnt   = 0;
    int m_leg   = 0;
    int m_req   = 0;
    int m_kd    = 0;
    int m_sel   = 0;
    int m_act   = 0;

    dino_motion_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .jump_key    (jump_key),
        .duck_key    (duck_key),
        .collide     (collide),
        .DinoX       (DinoX),
        .DinoY       (DinoY),
        .sprite_sel  (sprite_sel),
        .game_active (game_active)
    );

    always #5 Clk = ~Clk;

    task automatic model_step();
        int rise;
        int ny;
        rise = (jump_key && m_kd == 0) ? 1 : 0;
        m_kd = jump_key ? 1 : 0;
        if (Reset) begin
            m_state = 0; m_y = 300; m_vel = 0; m_cnt = 0; m_leg = 0; m_req = 0;
        end else begin
            if (m_state == 0) begin
                if (frame_tick && m_req == 1) m_state = 1;
            end else if (m_state == 1) begin
                if (collide) m_state = 3;
                else if (frame_tick && m_req == 1) begin
                    m_state = 2; m_vel = 20;
                end else if (frame_tick) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 5) begin
                        m_cnt = 0; m_leg = 1 - m_leg;
                    end
                end
            end else if (m_state == 2) begin
                if (collide) m_state = 3;
                else if (frame_tick) begin
                    ny = m_y - m_vel;
                    m_vel = m_vel - 1;
                    if (ny >= 300) begin
                        m_y = 300; m_vel = 0; m_state = 1;
                    end else if (ny < 0) m_y = 0;
                    else m_y = ny;
                end
            end else begin
                if (frame_tick && m_req == 1) begin
                    m_state = 1; m_y = 300; m_vel = 0; m_cnt = 0; m_leg = 0;
                end
            end
            if (frame_tick) m_req = rise;
            else if (rise == 1) m_req = 1;
        end
        case (m_state)
            0: m_sel = 0;
            1: m_sel = duck_key ? 3 + m_leg : 1 + m_leg;
            2: m_sel = 5;
            default: m_sel = 6;
        endcase
        m_act = (m_state == 1 || m_state == 2) ? 1 : 0;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: predict, push, advance past the edge, pop and compare.
    task automatic cyc(input string tag);
        exp_t e;
        model_step();
        e.tag = tag; e.y = m_y; e.sel = m_sel; e.act = m_act;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".y"},   int'(DinoY),       e.y);
        chk({e.tag, ".sel"}, int'(sprite_sel),  e.sel);
        chk({e.tag, ".act"}, int'(game_active), e.act);
        chk({e.tag, ".x"},   int'(DinoX),       50);
    endtask

    task automatic tick(input string tag);
        frame_tick = 1'b1; cyc(tag);
        frame_tick = 1'b0; cyc(tag);
    endtask

    task automatic press(input string tag);
        jump_key = 1'b1; cyc(tag);
        jump_key = 1'b0; cyc(tag);
    endtask

    initial begin
        // Reset state
        cyc("reset"); cyc("reset");
        chk("rst_y", int'(DinoY), 300);
        chk("rst_sel", int'(sprite_sel), 0);
        chk("rst_act", int'(game_active), 0);
        Reset = 1'b0;
        cyc("idle");
        tick("idle_tick_noreq");
        chk("idle_stays", int'(sprite_sel), 0);

        // Start running
        press("start");
        frame_tick = 1'b1; cyc("start_tick"); frame_tick = 1'b0;
        chk("start_sel", int'(sprite_sel), 1);
        chk("start_act", int'(game_active), 1);
        chk("start_y", int'(DinoY), 300);
        cyc("start");

        // Leg swap every five ticks, duck codes
        for (int i = 0; i < 5; i++) tick("run_a");
        chk("run_leg_b", int'(sprite_sel), 2);
        for (int i = 0; i < 5; i++) tick("run_b");
        chk("run_leg_a", int'(sprite_sel), 1);
        duck_key = 1'b1;
        cyc("duck");
        chk("duck_a", int'(sprite_sel), 3);
        for (int i = 0; i < 5; i++) tick("duck_run");
        chk("duck_b", int'(sprite_sel), 4);
        duck_key = 1'b0;
        cyc("unduck");

        // Full jump arc
        press("jump");
        frame_tick = 1'b1; cyc("takeoff"); frame_tick = 1'b0;
        chk("takeoff_sel", int'(sprite_sel), 5);
        chk("takeoff_y", int'(DinoY), 300);
        cyc("takeoff");
        tick("air1");
        chk("air1_y", int'(DinoY), 280);
        for (int k = 2; k <= 19; k++) tick("air");
        tick("air20");
        chk("apex20_y", int'(DinoY), 90);
        tick("air21");
        chk("apex21_y", int'(DinoY), 90);
        for (int k = 22; k <= 39; k++) tick("air");
        jump_key = 1'b1;
        cyc("hold");
        tick("air40");
        tick("land41");
        chk("land_y", int'(DinoY), 300);
        chk("land_sel", int'(sprite_sel), 2);
        chk("land_act", int'(game_active), 1);
        tick("held42");
        chk("held_no_jump", int'(sprite_sel), 2);
        jump_key = 1'b0;
        cyc("release");
        press("repress");
        tick("rejump");
        chk("rejump_sel", int'(sprite_sel), 5);

        // Reset mid-air with a pending request
        for (int k = 1; k <= 9; k++) tick("air_b");
        chk("air9_y", int'(DinoY), 156);
        press("pending");
        Reset = 1'b1;
        cyc("rst_air");
        chk("rst_air_y", int'(DinoY), 300);
        chk("rst_air_sel", int'(sprite_sel), 0);
        Reset = 1'b0;
        tick("post_rst");
        chk("req_cleared", int'(sprite_sel), 0);

        // Collide beats a jump on the same tick
        press("start2");
        tick("start2");
        chk("start2_sel", int'(sprite_sel), 1);
        press("arm");
        frame_tick = 1'b1; collide = 1'b1;
        cyc("collide_tick");
        frame_tick = 1'b0; collide = 1'b0;
        chk("dead_sel", int'(sprite_sel), 6);
        chk("dead_act", int'(game_active), 0);
        chk("dead_y", int'(DinoY), 300);
        cyc("dead");
        tick("dead_tick");
        chk("dead_stays", int'(sprite_sel), 6);
        press("revive");
        tick("revive");
        chk("revive_sel", int'(sprite_sel), 1);
        chk("revive_y", int'(DinoY), 300);

        // Collide in the air freezes the sprite where it is
        press("jump3");
        tick("takeoff3");
        for (int k = 1; k <= 3; k++) tick("air3");
        chk("air3_y", int'(DinoY), 243);
        collide = 1'b1;
        cyc("air_collide");
        collide = 1'b0;
        chk("air_dead_sel", int'(sprite_sel), 6);
        chk("air_dead_y", int'(DinoY), 243);
        tick("frozen");
        chk("frozen_y", int'(DinoY), 243);
        press("revive2");
        tick("revive2");
        chk("revive2_y", int'(DinoY), 300);
        chk("revive2_act", int'(game_active), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
